ddr3_port_arbiter: RTL and testbench

Shares the single DDR3 Avalon-MM master port (576-bit data, 27-bit word address, 7-bit burstcount) between the host read/write path and the SpMV engine. It sits between the two requesters and the DDR3 controller interface. It arbitrates commands, holds the grant for the full length of a write burst, and routes returning read beats to the requester that issued the read, using an in-order tag FIFO.

---
 rtl/ddr3_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 Avalon-MM master port between the host and SpMV requesters.
// Define DDR3_ARB_HOST_PRIO_EN for strict host priority instead of round-robin.
module ddr3_port_arbiter #(
  parameter int ADDRESS_SIZE = 27,
  parameter int RD_TAG_DEPTH = 8
) (
  input  logic                    ddr3_clk,
  input  logic                    ddr3_reset_n,

  input  logic [ADDRESS_SIZE-1:0] host_s_address,
  input  logic                    host_s_read,
  input  logic                    host_s_write,
  input  logic [575:0]            host_s_writedata,
  input  logic [71:0]             host_s_be,
  input  logic [6:0]              host_s_burstcount,
  output logic                    host_s_waitrequest,
  output logic [575:0]            host_s_readdata,
  output logic                    host_s_readdatavalid,

  input  logic [ADDRESS_SIZE-1:0] spmv_s_address,
  input  logic                    spmv_s_read,
  input  logic                    spmv_s_write,
  input  logic [575:0]            spmv_s_writedata,
  input  logic [71:0]             spmv_s_be,
  input  logic [6:0]              spmv_s_burstcount,
  output logic                    spmv_s_waitrequest,
  output logic [575:0]            spmv_s_readdata,
  output logic                    spmv_s_readdatavalid,

  output logic [ADDRESS_SIZE-1:0] arb_m0_address,
  output logic                    arb_m0_read,
  output logic                    arb_m0_write,
  output logic [575:0]            arb_m0_writedata,
  output logic [71:0]             arb_m0_be,
  output logic [6:0]              arb_m0_burstcount,
  input  logic                    arb_m0_waitrequest,
  input  logic [575:0]            arb_m0_readdata,
  input  logic                    arb_m0_readdatavalid,

  output logic                    arb_busy,
  output logic                    arb_err_orphan
);

  localparam int PTR_W = $clog2(RD_TAG_DEPTH);
  localparam logic HOST = 1'b0;
  localparam logic SPMV = 1'b1;

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t          state, state_next;
  logic [6:0]      beat_cnt, beat_cnt_next;
  logic            lock_owner, stall_locked, last_grant;
  logic            owner, host_act, spmv_act;
  logic            own_read, own_write, own_wait;
  logic [6:0]      own_bc, bc_eff;
  logic            accepted_write, push, pop, rdv_hit;
  logic            tag_empty, tag_full;

  logic            tag_id  [RD_TAG_DEPTH];
  logic [6:0]      tag_cnt [RD_TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]  tag_count;

  assign host_act = host_s_read | host_s_write;
  assign spmv_act = spmv_s_read | spmv_s_write;

  // Locked owner wins; otherwise a tie goes to priority or round-robin.
  always_comb begin
    owner = HOST;
    if (state == WR_BURST || stall_locked) begin
      owner = lock_owner;
    end else if (host_act && spmv_act) begin
`ifdef DDR3_ARB_HOST_PRIO_EN
      owner = HOST;
`else
      owner = (last_grant == HOST) ? SPMV : HOST;
`endif
    end else if (spmv_act) begin
      owner = SPMV;
    end
  end

  assign own_read  = owner ? spmv_s_read : host_s_read;
  assign own_write = (owner ? spmv_s_write : host_s_write) & ~own_read;
  assign own_bc    = owner ? spmv_s_burstcount : host_s_burstcount;
  assign bc_eff    = (own_bc == 7'd0) ? 7'd1 : own_bc;

  assign tag_empty = (tag_count == '0);
  assign rdv_hit   = ddr3_reset_n & arb_m0_readdatavalid & ~tag_empty;
  assign pop       = rdv_hit & (tag_cnt[rd_ptr] == 7'd1);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign tag_full  = (tag_count == (PTR_W+1)'(RD_TAG_DEPTH)) & ~pop;

  assign arb_m0_read       = ddr3_reset_n & own_read & ~tag_full;
  assign arb_m0_write      = ddr3_reset_n & own_write;
  assign arb_m0_address    = owner ? spmv_s_address : host_s_address;
  assign arb_m0_writedata  = owner ? spmv_s_writedata : host_s_writedata;
  assign arb_m0_be         = owner ? spmv_s_be : host_s_be;
  assign arb_m0_burstcount = own_bc;

  assign push           = arb_m0_read & ~arb_m0_waitrequest;
  assign accepted_write = arb_m0_write & ~arb_m0_waitrequest;

  assign own_wait           = arb_m0_waitrequest | (own_read & tag_full);
  assign host_s_waitrequest = ~ddr3_reset_n | (owner != HOST) | own_wait;
  assign spmv_s_waitrequest = ~ddr3_reset_n | (owner != SPMV) | own_wait;

  assign host_s_readdata      = arb_m0_readdata;
  assign spmv_s_readdata      = arb_m0_readdata;
  assign host_s_readdatavalid = rdv_hit & (tag_id[rd_ptr] == HOST);
  assign spmv_s_readdatavalid = rdv_hit & (tag_id[rd_ptr] == SPMV);

  assign arb_busy = ddr3_reset_n & ((state == WR_BURST) | ~tag_empty);

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (accepted_write && bc_eff > 7'd1) begin
          state_next    = WR_BURST;
          beat_cnt_next = bc_eff - 7'd1;
        end
      end
      WR_BURST: begin
        if (accepted_write) begin
          if (beat_cnt == 7'd1) begin
            state_next    = IDLE;
            beat_cnt_next = 7'd0;
          end else begin
            beat_cnt_next = beat_cnt - 7'd1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = 7'd0;
      end
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (!ddr3_reset_n) begin
      state          <= IDLE;
      beat_cnt       <= 7'd0;
      stall_locked   <= 1'b0;
      lock_owner     <= HOST;
      last_grant     <= SPMV;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tag_count      <= '0;
      arb_err_orphan <= 1'b0;
    end else begin
      state        <= state_next;
      beat_cnt     <= beat_cnt_next;
      stall_locked <= (arb_m0_read | arb_m0_write) & arb_m0_waitrequest;
      lock_owner   <= owner;
      if (push || (accepted_write && state == IDLE)) begin
        last_grant <= owner;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      tag_count <= tag_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (arb_m0_readdatavalid && tag_empty) begin
        arb_err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge ddr3_clk) begin
    if (rdv_hit && !pop) begin
      tag_cnt[rd_ptr] <= tag_cnt[rd_ptr] - 7'd1;
    end
    if (push) begin
      tag_id[wr_ptr]  <= owner;
      tag_cnt[wr_ptr] <= bc_eff;
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomized bench for ddr3_port_arbiter against a per-cycle model of the arbitration rules.
// Follows DDR3_ARB_HOST_PRIO_EN to select the expected tie-break policy.
module tb_ddr3_port_arbiter;

  localparam int DEPTH = 8;

  logic         ddr3_clk = 1'b0;
  logic         ddr3_reset_n;
  logic [26:0]  host_s_address, spmv_s_address, arb_m0_address;
  logic         host_s_read, host_s_write, spmv_s_read, spmv_s_write;
  logic [575:0] host_s_writedata, spmv_s_writedata, arb_m0_writedata;
  logic [71:0]  host_s_be, spmv_s_be, arb_m0_be;
  logic [6:0]   host_s_burstcount, spmv_s_burstcount, arb_m0_burstcount;
  logic         host_s_waitrequest, spmv_s_waitrequest;
  logic [575:0] host_s_readdata, spmv_s_readdata, arb_m0_readdata;
  logic         host_s_readdatavalid, spmv_s_readdatavalid;
  logic         arb_m0_read, arb_m0_write, arb_m0_waitrequest, arb_m0_readdatavalid;
  logic         arb_busy, arb_err_orphan;

  int checks = 0;
  int failures = 0;

  ddr3_port_arbiter #(.ADDRESS_SIZE(27), .RD_TAG_DEPTH(DEPTH)) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
    .host_s_address(host_s_address), .host_s_read(host_s_read), .host_s_write(host_s_write),
    .host_s_writedata(host_s_writedata), .host_s_be(host_s_be), .host_s_burstcount(host_s_burstcount),
    .host_s_waitrequest(host_s_waitrequest), .host_s_readdata(host_s_readdata),
    .host_s_readdatavalid(host_s_readdatavalid),
    .spmv_s_address(spmv_s_address), .spmv_s_read(spmv_s_read), .spmv_s_write(spmv_s_write),
    .spmv_s_writedata(spmv_s_writedata), .spmv_s_be(spmv_s_be), .spmv_s_burstcount(spmv_s_burstcount),
    .spmv_s_waitrequest(spmv_s_waitrequest), .spmv_s_readdata(spmv_s_readdata),
    .spmv_s_readdatavalid(spmv_s_readdatavalid),
    .arb_m0_address(arb_m0_address), .arb_m0_read(arb_m0_read), .arb_m0_write(arb_m0_write),
    .arb_m0_writedata(arb_m0_writedata), .arb_m0_be(arb_m0_be), .arb_m0_burstcount(arb_m0_burstcount),
    .arb_m0_waitrequest(arb_m0_waitrequest), .arb_m0_readdata(arb_m0_readdata),
    .arb_m0_readdatavalid(arb_m0_readdatavalid),
    .arb_busy(arb_busy), .arb_err_orphan(arb_err_orphan)
  );

  always #5 ddr3_clk = ~ddr3_clk;

  task automatic checkOutput(input string tag, input logic [575:0] observed, input logic [575:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model state: owner locks, last grant, and outstanding read bursts.
  bit prio;
  int burst_rem;
  bit burst_id, stall_valid, stall_id, last_id, orphan_m;
  int q_id[$];
  int q_rem[$];
  bit dut_acc[2];
  int owed_in = 0;
  int owed_out = 0;

  bit h_act, s_act, own, o_rd, o_wr, ne, pop_m, full_m, e_rd, e_wr, acc;
  logic [6:0] o_bc;
  int bce;

  initial begin
`ifdef DDR3_ARB_HOST_PRIO_EN
    prio = 1'b1;
`else
    prio = 1'b0;
`endif
  end

  always @(negedge ddr3_clk) begin
    if (!ddr3_reset_n) begin
      checkOutput("rst_m_read", arb_m0_read, 0);
      checkOutput("rst_m_write", arb_m0_write, 0);
      checkOutput("rst_h_wait", host_s_waitrequest, 1);
      checkOutput("rst_s_wait", spmv_s_waitrequest, 1);
      checkOutput("rst_h_rdv", host_s_readdatavalid, 0);
      checkOutput("rst_s_rdv", spmv_s_readdatavalid, 0);
      burst_rem = 0; stall_valid = 0; last_id = 1; orphan_m = 0;
      q_id.delete(); q_rem.delete();
      dut_acc[0] = 0; dut_acc[1] = 0;
    end else begin
      h_act = host_s_read | host_s_write;
      s_act = spmv_s_read | spmv_s_write;
      if (burst_rem > 0) own = burst_id;
      else if (stall_valid) own = stall_id;
      else if (h_act && s_act) own = prio ? 1'b0 : !last_id;
      else own = s_act;
      o_rd = own ? spmv_s_read : host_s_read;
      o_wr = (own ? spmv_s_write : host_s_write) && !o_rd;
      o_bc = own ? spmv_s_burstcount : host_s_burstcount;
      bce = (o_bc == 0) ? 1 : int'(o_bc);
      ne = q_id.size() > 0;
      pop_m = arb_m0_readdatavalid && ne && q_rem[0] == 1;
      full_m = (q_id.size() == DEPTH) && !pop_m;
      e_rd = o_rd && !full_m;
      e_wr = o_wr;

      checkOutput("m_read", arb_m0_read, e_rd);
      checkOutput("m_write", arb_m0_write, e_wr);
      checkOutput("h_wait", host_s_waitrequest, own ? 1'b1 : (arb_m0_waitrequest | (o_rd & full_m)));
      checkOutput("s_wait", spmv_s_waitrequest, !own ? 1'b1 : (arb_m0_waitrequest | (o_rd & full_m)));
      checkOutput("h_rdv", host_s_readdatavalid, arb_m0_readdatavalid && ne && q_id[0] == 0);
      checkOutput("s_rdv", spmv_s_readdatavalid, arb_m0_readdatavalid && ne && q_id[0] == 1);
      checkOutput("busy", arb_busy, (burst_rem > 0) || ne);
      checkOutput("orphan", arb_err_orphan, orphan_m);
      if (e_rd || e_wr) begin
        checkOutput("m_addr", arb_m0_address, own ? spmv_s_address : host_s_address);
        checkOutput("m_bc", arb_m0_burstcount, o_bc);
      end
      if (e_wr) begin
        checkOutput("m_wdata", arb_m0_writedata, own ? spmv_s_writedata : host_s_writedata);
        checkOutput("m_be", arb_m0_be, own ? spmv_s_be : host_s_be);
      end
      if (arb_m0_readdatavalid) begin
        checkOutput("h_rdata", host_s_readdata, arb_m0_readdata);
        checkOutput("s_rdata", spmv_s_readdata, arb_m0_readdata);
      end

      dut_acc[0] = h_act && !host_s_waitrequest;
      dut_acc[1] = s_act && !spmv_s_waitrequest;
      if (arb_m0_read && !arb_m0_waitrequest)
        owed_in += (arb_m0_burstcount == 0) ? 1 : int'(arb_m0_burstcount);

      if (arb_m0_readdatavalid) begin
        if (ne) begin
          q_rem[0] = q_rem[0] - 1;
          if (q_rem[0] == 0) begin
            void'(q_id.pop_front());
            void'(q_rem.pop_front());
          end
        end else begin
          orphan_m = 1;
        end
      end
      acc = (e_rd || e_wr) && !arb_m0_waitrequest;
      if (acc && e_rd) begin
        q_id.push_back(int'(own));
        q_rem.push_back(bce);
        last_id = own;
      end
      if (acc && e_wr) begin
        if (burst_rem == 0) begin
          last_id = own;
          if (bce > 1) begin
            burst_rem = bce - 1;
            burst_id = own;
          end
        end else begin
          burst_rem--;
        end
      end
      stall_valid = (e_rd || e_wr) && arb_m0_waitrequest;
      stall_id = own;
    end
  end

  // Requester behaviour: one transaction at a time, write bursts stream a new beat per acceptance.
  bit          rq_busy[2], rq_read[2];
  int          rq_left[2];
  logic [26:0] rq_addr[2];
  logic [575:0] rq_data[2];
  logic [71:0] rq_be[2];
  logic [6:0]  rq_bc[2];

  task automatic newData(input int i);
    for (int k = 0; k < 18; k++) rq_data[i][k*32 +: 32] = $urandom;
    rq_be[i] = {$urandom, $urandom, 8'($urandom)};
  endtask

  task automatic driveRequester(input int i, input int req_pct);
    if (!ddr3_reset_n) begin
      rq_busy[i] = 0;
    end else if (rq_busy[i] && dut_acc[i]) begin
      if (!rq_read[i] && rq_left[i] > 1) begin
        rq_left[i]--;
        newData(i);
      end else begin
        rq_busy[i] = 0;
      end
    end
    if (ddr3_reset_n && !rq_busy[i] && $urandom_range(99) < req_pct) begin
      rq_busy[i] = 1;
      rq_read[i] = 1'($urandom_range(1));
      rq_bc[i]   = 7'(rq_read[i] ? $urandom_range(3) : $urandom_range(4));
      rq_left[i] = (rq_bc[i] == 0) ? 1 : int'(rq_bc[i]);
      rq_addr[i] = {i[0], 26'($urandom)};
      newData(i);
    end
    if (i == 0) begin
      host_s_read = rq_busy[0] && rq_read[0];
      host_s_write = rq_busy[0] && !rq_read[0];
      host_s_address = rq_addr[0]; host_s_writedata = rq_data[0];
      host_s_be = rq_be[0]; host_s_burstcount = rq_bc[0];
    end else begin
      spmv_s_read = rq_busy[1] && rq_read[1];
      spmv_s_write = rq_busy[1] && !rq_read[1];
      spmv_s_address = rq_addr[1]; spmv_s_writedata = rq_data[1];
      spmv_s_be = rq_be[1]; spmv_s_burstcount = rq_bc[1];
    end
  endtask

  task automatic applyStimulus(input int cycles, input int req_pct, input int wait_pct, input int rdv_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge ddr3_clk); #1;
      for (int i = 0; i < 2; i++) driveRequester(i, req_pct);
      arb_m0_waitrequest = ($urandom_range(99) < wait_pct);
      if (owed_in > owed_out && $urandom_range(99) < rdv_pct) begin
        arb_m0_readdatavalid = 1;
        arb_m0_readdata = {18{$urandom}};
        owed_out++;
      end else begin
        arb_m0_readdatavalid = 0;
      end
    end
  endtask

  initial begin
    ddr3_reset_n = 0;
    host_s_read = 0; host_s_write = 0; spmv_s_read = 0; spmv_s_write = 0;
    host_s_address = '0; spmv_s_address = '0; host_s_writedata = '0; spmv_s_writedata = '0;
    host_s_be = '0; spmv_s_be = '0; host_s_burstcount = '0; spmv_s_burstcount = '0;
    arb_m0_waitrequest = 0; arb_m0_readdatavalid = 0; arb_m0_readdata = '0;

    applyStimulus(4, 0, 0, 0);
    ddr3_reset_n = 1;
    applyStimulus(1, 100, 0, 0);
    applyStimulus(800, 60, 30, 50);
    applyStimulus(400, 85, 10, 5);
    applyStimulus(300, 70, 70, 40);

    ddr3_reset_n = 0;
    applyStimulus(3, 50, 30, 50);
    ddr3_reset_n = 1;
    applyStimulus(600, 50, 20, 60);

    ddr3_reset_n = 0;
    owed_out = owed_in;
    applyStimulus(3, 0, 0, 0);
    ddr3_reset_n = 1;
    applyStimulus(2, 0, 0, 0);
    checkOutput("post_rst_orphan", arb_err_orphan, 0);
    checkOutput("post_rst_busy", arb_busy, 0);
    @(posedge ddr3_clk); #1;
    arb_m0_readdatavalid = 1;
    @(negedge ddr3_clk);
    checkOutput("orphan_no_h_rdv", host_s_readdatavalid, 0);
    checkOutput("orphan_no_s_rdv", spmv_s_readdatavalid, 0);
    @(posedge ddr3_clk); #1;
    arb_m0_readdatavalid = 0;
    @(negedge ddr3_clk);
    checkOutput("orphan_set", arb_err_orphan, 1);
    @(posedge ddr3_clk); #1;
    ddr3_reset_n = 0;
    @(posedge ddr3_clk); #1;
    ddr3_reset_n = 1;
    @(negedge ddr3_clk);
    checkOutput("orphan_cleared", arb_err_orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
